// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the writeback arbiter: per-unit result structs, the unified CDB entry and source ids.
// WB_ARB_BRANCH_PRIO_EN changes only how the round-robin pointer advances.
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_BR  = 2'd1,
        WB_LSU = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic        wr_en;
        logic [4:0]  rd;
        logic [31:0] value;
    } alu_out_t;

    typedef struct packed {
        logic        wr_en;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        mispredict;
        logic [31:0] target;
    } branch_out_t;

    typedef struct packed {
        logic        wr_en;
        logic [4:0]  rd;
        logic [31:0] value;
    } lsu_out_t;

    typedef struct packed {
        logic        valid_tag;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        mispredict;
        logic [31:0] target;
    } cdb_entry_t;

    function automatic cdb_entry_t alu_to_cdb(input alu_out_t a);
        cdb_entry_t c;
        c           = '0;
        c.valid_tag = a.wr_en;
        c.rd        = a.rd;
        c.value     = a.value;
        return c;
    endfunction

    function automatic cdb_entry_t br_to_cdb(input branch_out_t b);
        cdb_entry_t c;
        c            = '0;
        c.valid_tag  = b.wr_en;
        c.rd         = b.rd;
        c.value      = b.value;
        c.mispredict = b.mispredict;
        c.target     = b.target;
        return c;
    endfunction

    function automatic cdb_entry_t lsu_to_cdb(input lsu_out_t l);
        cdb_entry_t c;
        c           = '0;
        c.valid_tag = l.wr_en;
        c.rd        = l.rd;
        c.value     = l.value;
        return c;
    endfunction

    // Pointer after a grant; with branch priority the pointer only toggles between ALU and LSU.
    function automatic wb_src_e next_ptr(input wb_src_e granted, input wb_src_e cur);
        wb_src_e n;
        n = cur;
`ifdef WB_ARB_BRANCH_PRIO_EN
        case (granted)
            WB_ALU:  n = WB_LSU;
            WB_LSU:  n = WB_ALU;
            default: n = cur;
        endcase
`else
        case (granted)
            WB_ALU:  n = WB_BR;
            WB_BR:   n = WB_LSU;
            default: n = WB_ALU;
        endcase
`endif
        return n;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_arb3.sv
// Combinational 3-way grant: one-hot gnt from req and the round-robin pointer.
// With WB_ARB_BRANCH_PRIO_EN defined, the branch request always wins.
module rr_arb3
    import wb_arbiter_pkg::*;
(
    input  logic [2:0] req_i,
    input  wb_src_e    ptr_i,
    output logic [2:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
`ifdef WB_ARB_BRANCH_PRIO_EN
        if (req_i[WB_BR]) begin
            gnt_o[WB_BR] = 1'b1;
        end else if (ptr_i == WB_LSU) begin
            if (req_i[WB_LSU])      gnt_o[WB_LSU] = 1'b1;
            else if (req_i[WB_ALU]) gnt_o[WB_ALU] = 1'b1;
        end else begin
            if (req_i[WB_ALU])      gnt_o[WB_ALU] = 1'b1;
            else if (req_i[WB_LSU]) gnt_o[WB_LSU] = 1'b1;
        end
`else
        case (ptr_i)
            WB_BR: begin
                if (req_i[WB_BR])       gnt_o[WB_BR]  = 1'b1;
                else if (req_i[WB_LSU]) gnt_o[WB_LSU] = 1'b1;
                else if (req_i[WB_ALU]) gnt_o[WB_ALU] = 1'b1;
            end
            WB_LSU: begin
                if (req_i[WB_LSU])      gnt_o[WB_LSU] = 1'b1;
                else if (req_i[WB_ALU]) gnt_o[WB_ALU] = 1'b1;
                else if (req_i[WB_BR])  gnt_o[WB_BR]  = 1'b1;
            end
            default: begin
                if (req_i[WB_ALU])      gnt_o[WB_ALU] = 1'b1;
                else if (req_i[WB_BR])  gnt_o[WB_BR]  = 1'b1;
                else if (req_i[WB_LSU]) gnt_o[WB_LSU] = 1'b1;
            end
        endcase
`endif
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin selection of ALU/branch/LSU results into a single registered CDB slot.
// Define WB_ARB_BRANCH_PRIO_EN to give the branch source fixed highest priority.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter type AO = alu_out_t,
    parameter type BO = branch_out_t,
    parameter type LO = lsu_out_t,
    parameter type CE = cdb_entry_t
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       flush_i,
    input  logic       alu_valid_i,
    output logic       alu_ready_o,
    input  AO          alu_data_i,
    input  logic       b_valid_i,
    output logic       b_ready_o,
    input  BO          b_data_i,
    input  logic       lsu_valid_i,
    output logic       lsu_ready_o,
    input  LO          lsu_data_i,
    output logic       cdb_valid_o,
    input  logic       cdb_ready_i,
    output CE          cdb_data_o,
    output logic [1:0] cdb_src_o
);

    logic       slotFree;
    logic       grantEn;
    logic [2:0] req;
    logic [2:0] gnt;
    wb_src_e    win;
    CE          winData;

    wb_src_e    ptr_q,      ptr_d;
    logic       cdbValid_q, cdbValid_d;
    CE          cdbData_q,  cdbData_d;
    wb_src_e    cdbSrc_q,   cdbSrc_d;

    // The slot may refill in the cycle it drains; reset and flush suppress all grants.
    always_comb begin
        slotFree = !cdbValid_q || cdb_ready_i;
        grantEn  = slotFree && !flush_i && !reset_i;
        req      = {lsu_valid_i, b_valid_i, alu_valid_i} & {3{grantEn}};
    end

    rr_arb3 u_rr_arb3 (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    assign alu_ready_o = gnt[WB_ALU];
    assign b_ready_o   = gnt[WB_BR];
    assign lsu_ready_o = gnt[WB_LSU];

    always_comb begin
        win     = WB_ALU;
        winData = alu_to_cdb(alu_data_i);
        if (gnt[WB_BR]) begin
            win     = WB_BR;
            winData = br_to_cdb(b_data_i);
        end else if (gnt[WB_LSU]) begin
            win     = WB_LSU;
            winData = lsu_to_cdb(lsu_data_i);
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        cdbValid_d = cdbValid_q;
        cdbData_d  = cdbData_q;
        cdbSrc_d   = cdbSrc_q;
        if (flush_i) begin
            cdbValid_d = 1'b0;
        end else if (|gnt) begin
            cdbValid_d = 1'b1;
            cdbData_d  = winData;
            cdbSrc_d   = win;
            ptr_d      = next_ptr(win, ptr_q);
        end else if (cdb_ready_i) begin
            cdbValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q      <= WB_ALU;
            cdbValid_q <= 1'b0;
            cdbData_q  <= '0;
            cdbSrc_q   <= WB_ALU;
        end else begin
            ptr_q      <= ptr_d;
            cdbValid_q <= cdbValid_d;
            cdbData_q  <= cdbData_d;
            cdbSrc_q   <= cdbSrc_d;
        end
    end

    assign cdb_valid_o = cdbValid_q;
    assign cdb_data_o  = cdbData_q;
    assign cdb_src_o   = cdbSrc_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, short hand sequences, then random traffic vs. a reference model.
// Honours WB_ARB_BRANCH_PRIO_EN the same way as the design.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        aluValid, bValid, lsuValid;
    logic        aluReady, bReady, lsuReady;
    alu_out_t    aluData;
    branch_out_t bData;
    lsu_out_t    lsuData;
    logic        cdbValid;
    logic        cdbReady;
    cdb_entry_t  cdbData;
    logic [1:0]  cdbSrc;

    int checks = 0;
    int errors = 0;

    wb_arbiter dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (flush),
        .alu_valid_i (aluValid),
        .alu_ready_o (aluReady),
        .alu_data_i  (aluData),
        .b_valid_i   (bValid),
        .b_ready_o   (bReady),
        .b_data_i    (bData),
        .lsu_valid_i (lsuValid),
        .lsu_ready_o (lsuReady),
        .lsu_data_i  (lsuData),
        .cdb_valid_o (cdbValid),
        .cdb_ready_i (cdbReady),
        .cdb_data_o  (cdbData),
        .cdb_src_o   (cdbSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {reset, flush, aluValid, bValid, lsuValid, cdbReady}
    typedef struct {
        logic [5:0]  ctl;
        logic [2:0]  expReady;
        logic        expValid;
        logic [1:0]  expSrc;
        logic [31:0] expValue;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] ctl);
        reset    = ctl[5];
        flush    = ctl[4];
        aluValid = ctl[3];
        bValid   = ctl[2];
        lsuValid = ctl[1];
        cdbReady = ctl[0];
    endtask

    // Reference model state: contents of the output slot and the next source to favour.
    int         mPtr;
    bit         mValid;
    int         mSrc;
    cdb_entry_t mData;

    function automatic int pickWinner(input bit [2:0] v, input int p);
`ifdef WB_ARB_BRANCH_PRIO_EN
        if (v[1]) return 1;
        if (p == 2) begin
            if (v[2]) return 2;
            if (v[0]) return 0;
        end else begin
            if (v[0]) return 0;
            if (v[2]) return 2;
        end
        return -1;
`else
        for (int k = 0; k < 3; k++) begin
            int s;
            s = (p + k) % 3;
            if (v[s]) return s;
        end
        return -1;
`endif
    endfunction

    function automatic int ptrAfter(input int w, input int p);
`ifdef WB_ARB_BRANCH_PRIO_EN
        if (w == 1) return p;
        return (w == 0) ? 2 : 0;
`else
        return (w + 1) % 3;
`endif
    endfunction

    function automatic cdb_entry_t entryFor(input int s);
        cdb_entry_t e;
        e = '0;
        if (s == 0) begin
            e.valid_tag = aluData.wr_en;  e.rd = aluData.rd;  e.value = aluData.value;
        end else if (s == 1) begin
            e.valid_tag = bData.wr_en;    e.rd = bData.rd;    e.value = bData.value;
            e.mispredict = bData.mispredict;
            e.target     = bData.target;
        end else begin
            e.valid_tag = lsuData.wr_en;  e.rd = lsuData.rd;  e.value = lsuData.value;
        end
        return e;
    endfunction

    initial begin
        applyStimulus(6'b100001);
        aluData = '{wr_en: 1'b1, rd: 5'd5, value: 32'h1234};
        bData   = '{wr_en: 1'b1, rd: 5'd7, value: 32'hB0B0, mispredict: 1'b1, target: 32'h8000};
        lsuData = '{wr_en: 1'b1, rd: 5'd9, value: 32'h5A5A};

`ifdef WB_ARB_BRANCH_PRIO_EN
        vecs.push_back('{6'b100001, 3'b000, 1'b0, 2'd0, 32'h0});
        vecs.push_back('{6'b001111, 3'b010, 1'b1, 2'd1, 32'hB0B0});
        vecs.push_back('{6'b001111, 3'b010, 1'b1, 2'd1, 32'hB0B0});
        vecs.push_back('{6'b001111, 3'b010, 1'b1, 2'd1, 32'hB0B0});
        vecs.push_back('{6'b001011, 3'b001, 1'b1, 2'd0, 32'h1234});
        vecs.push_back('{6'b001011, 3'b100, 1'b1, 2'd2, 32'h5A5A});
        vecs.push_back('{6'b001011, 3'b001, 1'b1, 2'd0, 32'h1234});
        vecs.push_back('{6'b000001, 3'b000, 1'b0, 2'd0, 32'h0});
`else
        vecs.push_back('{6'b100001, 3'b000, 1'b0, 2'd0, 32'h0});
        vecs.push_back('{6'b001001, 3'b001, 1'b1, 2'd0, 32'h1234});
        vecs.push_back('{6'b000001, 3'b000, 1'b0, 2'd0, 32'h0});
        vecs.push_back('{6'b100001, 3'b000, 1'b0, 2'd0, 32'h0});
        vecs.push_back('{6'b001111, 3'b001, 1'b1, 2'd0, 32'h1234});
        vecs.push_back('{6'b001111, 3'b010, 1'b1, 2'd1, 32'hB0B0});
        vecs.push_back('{6'b001111, 3'b100, 1'b1, 2'd2, 32'h5A5A});
        vecs.push_back('{6'b001111, 3'b001, 1'b1, 2'd0, 32'h1234});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{6'b001110, 3'b000, 1'b1, 2'd0, 32'h1234});
        vecs.push_back('{6'b001111, 3'b010, 1'b1, 2'd1, 32'hB0B0});
        vecs.push_back('{6'b001111, 3'b100, 1'b1, 2'd2, 32'h5A5A});
        vecs.push_back('{6'b001110, 3'b000, 1'b1, 2'd2, 32'h5A5A});
        vecs.push_back('{6'b011110, 3'b000, 1'b0, 2'd0, 32'h0});
        vecs.push_back('{6'b001111, 3'b001, 1'b1, 2'd0, 32'h1234});
        vecs.push_back('{6'b101111, 3'b000, 1'b0, 2'd0, 32'h0});
        vecs.push_back('{6'b001111, 3'b001, 1'b1, 2'd0, 32'h1234});
        vecs.push_back('{6'b000001, 3'b000, 1'b0, 2'd0, 32'h0});
`endif

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ctl);
            #1;
            checkOutput($sformatf("vec%0d_ready", i), 128'({lsuReady, bReady, aluReady}), 128'(vecs[i].expReady));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_valid", i), 128'(cdbValid), 128'(vecs[i].expValid));
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d_src", i), 128'(cdbSrc), 128'(vecs[i].expSrc));
                checkOutput($sformatf("vec%0d_value", i), 128'(cdbData.value), 128'(vecs[i].expValue));
            end
        end

        // Single ALU result carries rd through; then reset while the slot holds a branch entry.
        applyStimulus(6'b100001);
        @(posedge clk); #1;
        applyStimulus(6'b001001);
        @(posedge clk); #1;
        checkOutput("alu_rd", 128'(cdbData.rd), 128'(5));
        checkOutput("alu_tag", 128'(cdbData.valid_tag), 128'(1));
        applyStimulus(6'b001111);
        @(posedge clk); #1;
        checkOutput("br_src", 128'(cdbSrc), 128'(1));
        checkOutput("br_target", 128'(cdbData.target), 128'(32'h8000));
        applyStimulus(6'b101110);
        #1;
        checkOutput("reset_ready", 128'({lsuReady, bReady, aluReady}), 128'(0));
        @(posedge clk); #1;
        checkOutput("reset_valid", 128'(cdbValid), 128'(0));
        checkOutput("reset_data", 128'(cdbData), 128'(0));
        checkOutput("reset_src", 128'(cdbSrc), 128'(0));

        // Randomised traffic; the first cycle is a reset so the model starts in step.
        mPtr = 0; mValid = 0; mSrc = 0; mData = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [5:0] ctl;
            int         win;
            bit         free;
            ctl[5] = (cyc == 0) || ($urandom_range(0, 59) == 0);
            ctl[4] = ($urandom_range(0, 19) == 0);
            ctl[3] = ($urandom_range(0, 9) < 6);
            ctl[2] = ($urandom_range(0, 9) < 5);
            ctl[1] = ($urandom_range(0, 9) < 6);
            ctl[0] = ($urandom_range(0, 9) < 7);
            applyStimulus(ctl);
            aluData = '{wr_en: 1'($urandom), rd: 5'($urandom), value: $urandom};
            bData   = '{wr_en: 1'($urandom), rd: 5'($urandom), value: $urandom,
                        mispredict: 1'($urandom), target: $urandom};
            lsuData = '{wr_en: 1'($urandom), rd: 5'($urandom), value: $urandom};
            #1;
            free = !mValid || cdbReady;
            win  = (!reset && !flush && free) ? pickWinner({lsuValid, bValid, aluValid}, mPtr) : -1;
            checkOutput($sformatf("rnd%0d_ready", cyc), 128'({lsuReady, bReady, aluReady}),
                        (win >= 0) ? 128'(1) << win : 128'(0));
            if (reset) begin
                mValid = 0; mPtr = 0; mSrc = 0; mData = '0;
            end else if (flush) begin
                mValid = 0;
            end else if (win >= 0) begin
                mValid = 1; mSrc = win; mData = entryFor(win); mPtr = ptrAfter(win, mPtr);
            end else if (cdbReady) begin
                mValid = 0;
            end
            @(posedge clk);
            #1;
            checkOutput($sformatf("rnd%0d_valid", cyc), 128'(cdbValid), 128'(mValid));
            if (mValid || reset) begin
                checkOutput($sformatf("rnd%0d_src", cyc), 128'(cdbSrc), 128'(mSrc));
                checkOutput($sformatf("rnd%0d_data", cyc), 128'(cdbData), 128'(mData));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
